// File: rtl/pc_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_stage_if
// Description : Bundle of the fetch-stage signals: instruction-memory address
//               and data, execute redirect, decode handshake and fault report.
//               master : the fetch stage (drives pc_o, id_*, fault*)
//               slave  : the surroundings (imem, execute, decode)
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_fetch_stage_if;
  logic [31:0] pc_o;            // fetch address to instruction memory
  logic [31:0] im_in;           // instruction word for pc_o, same cycle
  logic        redirect_valid;  // execute requests a PC change
  logic [31:0] redirect_pc;     // new fetch address
  logic        id_valid;        // head buffer entry valid
  logic [31:0] id_pc;           // PC of head entry
  logic [31:0] id_instr;        // instruction of head entry
  logic        id_ready;        // decode accepts head entry
  logic        fault;           // sticky fault flag
  logic [31:0] fault_pc;        // faulting fetch address

  modport master (
    output pc_o,
    input  im_in,
    input  redirect_valid,
    input  redirect_pc,
    output id_valid,
    output id_pc,
    output id_instr,
    input  id_ready,
    output fault,
    output fault_pc
  );

  modport slave (
    input  pc_o,
    output im_in,
    output redirect_valid,
    output redirect_pc,
    input  id_valid,
    input  id_pc,
    input  id_instr,
    output id_ready,
    input  fault,
    input  fault_pc
  );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : pc_fetch_stage
// Description : RV32IM fetch stage. Owns the PC, drives it to instruction
//               memory, captures {pc,instr} into a 2-entry buffer and hands
//               the head entry to decode with valid/ready. Redirects from
//               execute flush the buffer; misaligned or out-of-range fetch
//               addresses latch a sticky fault and stop fetching.
// Ports       : clk   - core clock, rising edge
//               reset - asynchronous, active-low reset
//               bus   - pc_fetch_stage_if.master (imem, redirect, decode,
//                       fault signals)
// Revision    : 1.0 - initial release
// ============================================================================
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 84
) (
  input  wire logic              clk,
  input  wire logic              reset,
  pc_fetch_stage_if.master       bus
);

  localparam logic [31:0] c_imem_limit = 32'(IMEM_BYTES);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [1:0]  r_count;
  logic        r_id_valid;
  logic [31:0] r_head_pc;
  logic [31:0] r_head_instr;
  logic [31:0] r_tail_pc;
  logic [31:0] r_tail_instr;
  logic        r_fault;
  logic [31:0] r_fault_pc;

  logic        w_pop;
  logic        w_space;
  logic        w_bad_pc;
  logic        w_try;
  logic        w_fault;
  logic        w_push;
  logic [1:0]  w_occ;        // occupancy after the pop, before the push
  logic [1:0]  w_count_nxt;

  always_comb begin
    w_pop       = r_id_valid & bus.id_ready;
    w_space     = (r_count < 2'd2) | w_pop;
    w_bad_pc    = (r_pc[1:0] != 2'b00) | (r_pc >= c_imem_limit);
    // A fetch is only attempted (and therefore checked) when it could push.
    w_try       = (r_state == ST_RUN) & ~bus.redirect_valid & w_space;
    w_fault     = w_try & w_bad_pc;
    w_push      = w_try & ~w_bad_pc;
    w_occ       = r_count - {1'b0, w_pop};
    w_count_nxt = w_occ + {1'b0, w_push};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_pc         <= RESET_PC;
      r_count      <= 2'd0;
      r_id_valid   <= 1'b0;
      r_head_pc    <= 32'd0;
      r_head_instr <= 32'd0;
      r_tail_pc    <= 32'd0;
      r_tail_instr <= 32'd0;
      r_fault      <= 1'b0;
      r_fault_pc   <= 32'd0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.redirect_valid) begin
            // Flush wins over any pop decode presents this cycle.
            r_count    <= 2'd0;
            r_id_valid <= 1'b0;
            r_pc       <= bus.redirect_pc;
          end else if (w_fault) begin
            r_state    <= ST_FAULT;
            r_fault    <= 1'b1;
            r_fault_pc <= r_pc;
            r_count    <= 2'd0;
            r_id_valid <= 1'b0;
          end else begin
            // Popping from a full buffer promotes the tail entry to head.
            if (w_pop && (r_count == 2'd2)) begin
              r_head_pc    <= r_tail_pc;
              r_head_instr <= r_tail_instr;
            end
            // New entry lands in the first slot left free after the pop.
            if (w_push) begin
              if (w_occ == 2'd0) begin
                r_head_pc    <= r_pc;
                r_head_instr <= bus.im_in;
              end else begin
                r_tail_pc    <= r_pc;
                r_tail_instr <= bus.im_in;
              end
              r_pc <= r_pc + 32'd4;
            end
            r_count    <= w_count_nxt;
            r_id_valid <= (w_count_nxt != 2'd0);
          end
        end
        ST_FAULT: begin
          r_count    <= 2'd0;
          r_id_valid <= 1'b0;
        end
        default: begin
          r_state <= ST_FAULT;
        end
      endcase
    end
  end

  assign bus.pc_o     = r_pc;
  assign bus.id_valid = r_id_valid;
  assign bus.id_pc    = r_head_pc;
  assign bus.id_instr = r_head_instr;
  assign bus.fault    = r_fault;
  assign bus.fault_pc = r_fault_pc;

endmodule
`default_nettype wire
